// File: rtl/btn_cond_pkg.sv
// Shared types and default constants for the pushbutton conditioner.
// Channel FSM states plus a helper that sizes the shared counter width.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        ST_LOW    = 2'd0,
        ST_CHK_HI = 2'd1,
        ST_HIGH   = 2'd2,
        ST_CHK_LO = 2'd3
    } btn_state_e;

    localparam int DEF_NUM_BTN           = 2;
    localparam int DEF_SYNC_STAGES       = 2;
    localparam int DEF_DEBOUNCE_CYCLES   = 10000;
    localparam int DEF_LONG_PRESS_CYCLES = 2000000;

    // Wide enough to hold the larger of the two cycle limits inclusive.
    function automatic int cnt_width(input int debounce_cycles, input int long_press_cycles);
        int biggest;
        biggest = (debounce_cycles > long_press_cycles) ? debounce_cycles : long_press_cycles;
        return $clog2(biggest + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: synchroniser, debounce FSM with stability counter and
// registered level/edge pulses. Optional hold counter under BTN_LONG_PRESS_EN.
module btn_debounce_ch
    import btn_cond_pkg::*;
#(
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_raw_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o,
    output logic long_press_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a single-cycle debounce the entry value must already be the last count.
    localparam logic [CNT_W-1:0] CNT_ENTRY = (DEBOUNCE_CYCLES > 1) ? CNT_ONE : CNT_ZERO;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_sync;

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
        end
    end

    assign s_sync = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = CNT_ZERO;
        unique case (state_q)
            ST_LOW: begin
                if (s_sync) begin
                    state_d = ST_CHK_HI;
                    cnt_d   = CNT_ENTRY;
                end
            end
            ST_CHK_HI: begin
                if (!s_sync) begin
                    state_d = ST_LOW;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HIGH: begin
                if (!s_sync) begin
                    state_d = ST_CHK_LO;
                    cnt_d   = CNT_ENTRY;
                end
            end
            ST_CHK_LO: begin
                if (s_sync) begin
                    state_d = ST_HIGH;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_LOW;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_LOW;
            end
        endcase
    end

    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (state_q == ST_CHK_HI && s_sync && cnt_q == CNT_LAST) begin
            level_d = 1'b1;
            rise_d  = 1'b1;
        end
        if (state_q == ST_CHK_LO && !s_sync && cnt_q == CNT_LAST) begin
            level_d = 1'b0;
            fall_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(LONG_PRESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_SAT  = CNT_W'(LONG_PRESS_CYCLES);

    logic [CNT_W-1:0] hold_q, hold_d;
    logic             lp_q, lp_d;

    // Parking at HOLD_SAT (one past the trigger) guarantees one pulse per press.
    always_comb begin
        hold_d = hold_q;
        lp_d   = 1'b0;
        if (!level_d) begin
            hold_d = CNT_ZERO;
        end else if (level_q) begin
            if (hold_q != HOLD_SAT) begin
                hold_d = hold_q + CNT_ONE;
            end
            lp_d = (hold_q == HOLD_LAST);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hold_q <= '0;
            lp_q   <= 1'b0;
        end else begin
            hold_q <= hold_d;
            lp_q   <= lp_d;
        end
    end

    assign long_press_o = lp_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Pushbutton conditioner: NUM_BTN independent synchronise/debounce channels.
// Define BTN_LONG_PRESS_EN to build the per-channel long-press detectors.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int NUM_BTN           = DEF_NUM_BTN,
    parameter int SYNC_STAGES       = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES   = DEF_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEF_LONG_PRESS_CYCLES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_BTN-1:0] btn_raw,
    output logic [NUM_BTN-1:0] btn_level,
    output logic [NUM_BTN-1:0] btn_rise,
    output logic [NUM_BTN-1:0] btn_fall,
    output logic [NUM_BTN-1:0] long_press
);

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_ch
        btn_debounce_ch #(
            .SYNC_STAGES      (SYNC_STAGES),
            .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
            .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
        ) u_ch (
            .clk_i       (clk),
            .rst_ni      (rst_n),
            .btn_raw_i   (btn_raw[g]),
            .level_o     (btn_level[g]),
            .rise_o      (btn_rise[g]),
            .fall_o      (btn_fall[g]),
            .long_press_o(long_press[g])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed latency/glitch/reset scenarios plus
// randomised bouncing checked against a run-length debounce model.
module tb_button_conditioner;

    localparam int NB = 2;
    localparam int SS = 2;
    localparam int DB = 4;
    localparam int LP = 16;

    logic          clk;
    logic          rst_n;
    logic [NB-1:0] btn_raw;
    logic [NB-1:0] btn_level;
    logic [NB-1:0] btn_rise;
    logic [NB-1:0] btn_fall;
    logic [NB-1:0] long_press;

    int tests_run;
    int tests_failed;

    // Model: the FSM sees raw values delayed SS edges; a level flips once DB
    // consecutive samples disagree with it.
    logic [NB-1:0] hist[$];
    logic [NB-1:0] m_level, m_rise, m_fall, m_lp;
    int            m_run[NB];
    int            m_hold[NB];

    button_conditioner #(
        .NUM_BTN          (NB),
        .SYNC_STAGES      (SS),
        .DEBOUNCE_CYCLES  (DB),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_raw   (btn_raw),
        .btn_level (btn_level),
        .btn_rise  (btn_rise),
        .btn_fall  (btn_fall),
        .long_press(long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < SS; i++) hist.push_back('0);
        m_level = '0;
        m_rise  = '0;
        m_fall  = '0;
        m_lp    = '0;
        for (int c = 0; c < NB; c++) begin
            m_run[c]  = 0;
            m_hold[c] = 0;
        end
    endtask

    task automatic model_edge(input logic [NB-1:0] raw);
        logic [NB-1:0] s;
        logic          prev;
        s = hist.pop_front();
        hist.push_back(raw);
        m_rise = '0;
        m_fall = '0;
        m_lp   = '0;
        for (int c = 0; c < NB; c++) begin
            prev = m_level[c];
            if (s[c] != m_level[c]) begin
                m_run[c]++;
                if (m_run[c] == DB) begin
                    m_level[c] = s[c];
                    m_rise[c]  = s[c];
                    m_fall[c]  = ~s[c];
                    m_run[c]   = 0;
                end
            end else begin
                m_run[c] = 0;
            end
            if (!m_level[c]) begin
                m_hold[c] = 0;
            end else if (prev && m_hold[c] < LP) begin
                m_hold[c]++;
`ifdef BTN_LONG_PRESS_EN
                if (m_hold[c] == LP) m_lp[c] = 1'b1;
`endif
            end
        end
    endtask

    // Drive raw for one clock, then advance the model past that edge.
    task automatic step(input logic [NB-1:0] raw);
        btn_raw = raw;
        @(posedge clk);
        #1;
        if (!rst_n) model_reset();
        else model_edge(raw);
    endtask

    task automatic settle();
        for (int i = 0; i < 10; i++) begin
            step('0);
            tests_run++;
            if ({btn_level, btn_rise, btn_fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
                tests_failed++;
                $display("FAIL settle: got lvl=%b r=%b f=%b lp=%b want lvl=%b r=%b f=%b lp=%b",
                         btn_level, btn_rise, btn_fall, long_press, m_level, m_rise, m_fall, m_lp);
            end
        end
    endtask

    task automatic test_reset();
        btn_raw = 2'b11;
        rst_n   = 1'b0;
        model_reset();
        #2;
        for (int i = 0; i < 5; i++) begin
            step(2'b11);
            tests_run++;
            if ({btn_level, btn_rise, btn_fall, long_press} !== 8'h00) begin
                tests_failed++;
                $display("FAIL reset_outputs: got %b want all zero",
                         {btn_level, btn_rise, btn_fall, long_press});
            end
        end
        // Button held through release: full debounce latency from release.
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(2'b11);
            tests_run++;
            if (btn_rise !== ((i == 6) ? 2'b11 : 2'b00) || btn_level !== ((i >= 6) ? 2'b11 : 2'b00)) begin
                tests_failed++;
                $display("FAIL held_through_reset edge %0d: got rise=%b lvl=%b", i, btn_rise, btn_level);
            end
        end
        settle();
    endtask

    task automatic test_latency();
        for (int i = 1; i <= 9; i++) begin
            step(2'b01);
            tests_run++;
            if (btn_rise !== ((i == 6) ? 2'b01 : 2'b00) || btn_level !== ((i >= 6) ? 2'b01 : 2'b00)
                || btn_fall !== 2'b00) begin
                tests_failed++;
                $display("FAIL rise_latency edge %0d: got rise=%b lvl=%b fall=%b", i, btn_rise, btn_level, btn_fall);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            step(2'b00);
            tests_run++;
            if (btn_fall !== ((i == 6) ? 2'b01 : 2'b00) || btn_level !== ((i < 6) ? 2'b01 : 2'b00)
                || btn_rise !== 2'b00) begin
                tests_failed++;
                $display("FAIL fall_latency edge %0d: got fall=%b lvl=%b rise=%b", i, btn_fall, btn_level, btn_rise);
            end
        end
    endtask

    task automatic test_glitch();
        logic [NB-1:0] pat[$];
        for (int i = 0; i < 3; i++) step(2'b01);
        for (int i = 0; i < 10; i++) begin
            step(2'b00);
            tests_run++;
            if (btn_level !== 2'b00 || btn_rise !== 2'b00) begin
                tests_failed++;
                $display("FAIL short_glitch: got lvl=%b rise=%b want 00 00", btn_level, btn_rise);
            end
        end
        pat = '{2'b01, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
        foreach (pat[k]) begin
            step(pat[k]);
            tests_run++;
            if ({btn_level, btn_rise, btn_fall} !== {m_level, m_rise, m_fall}) begin
                tests_failed++;
                $display("FAIL bounce step %0d: got lvl=%b r=%b f=%b want lvl=%b r=%b f=%b",
                         k, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
            end
        end
        settle();
    endtask

    task automatic test_simultaneous();
        for (int i = 1; i <= 8; i++) begin
            step(2'b11);
            tests_run++;
            if (btn_rise !== ((i == 6) ? 2'b11 : 2'b00)) begin
                tests_failed++;
                $display("FAIL simultaneous_rise edge %0d: got %b", i, btn_rise);
            end
        end
        settle();
    endtask

    task automatic test_reset_mid_check();
        for (int i = 0; i < 4; i++) step(2'b01);
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({btn_level, btn_rise, btn_fall} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_check_async: got %b want 0", {btn_level, btn_rise, btn_fall});
        end
        step(2'b01);
        step(2'b01);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step(2'b01);
            tests_run++;
            if (btn_rise !== ((i == 6) ? 2'b01 : 2'b00) || btn_rise !== m_rise) begin
                tests_failed++;
                $display("FAIL restart_after_reset edge %0d: got rise=%b want %b", i, btn_rise, m_rise);
            end
        end
        settle();
    endtask

    task automatic test_long_press();
        int lp_cnt, lp_at, rise_at;
        lp_cnt  = 0;
        lp_at   = -1;
        rise_at = -1;
        for (int i = 1; i <= 40; i++) begin
            step(2'b01);
            if (btn_rise[0]) rise_at = i;
            if (long_press[0]) begin
                lp_cnt++;
                lp_at = i;
            end
            tests_run++;
            if (long_press !== m_lp) begin
                tests_failed++;
                $display("FAIL long_press_model edge %0d: got %b want %b", i, long_press, m_lp);
            end
        end
        tests_run++;
`ifdef BTN_LONG_PRESS_EN
        if (lp_cnt != 1 || lp_at != rise_at + LP) begin
            tests_failed++;
            $display("FAIL long_press_pulse: got count=%0d at=%0d want count=1 at=%0d", lp_cnt, lp_at, rise_at + LP);
        end
`else
        if (lp_cnt != 0) begin
            tests_failed++;
            $display("FAIL long_press_disabled: got count=%0d want 0", lp_cnt);
        end
`endif
        settle();
    endtask

    task automatic test_random();
        logic [NB-1:0] raw;
        int            left[NB];
        raw = '0;
        for (int c = 0; c < NB; c++) left[c] = 0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < NB; c++) begin
                if (left[c] == 0) begin
                    raw[c]  = ~raw[c];
                    left[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(6, 30) : $urandom_range(1, 7);
                end
                left[c]--;
            end
            step(raw);
            tests_run++;
            if ({btn_level, btn_rise, btn_fall, long_press} !== {m_level, m_rise, m_fall, m_lp}) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got lvl=%b r=%b f=%b lp=%b want lvl=%b r=%b f=%b lp=%b",
                         i, btn_level, btn_rise, btn_fall, long_press, m_level, m_rise, m_fall, m_lp);
            end
        end
        settle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        btn_raw      = '0;
        rst_n        = 1'b1;
        test_reset();
        test_latency();
        test_glitch();
        test_simultaneous();
        test_reset_mid_check();
        test_long_press();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
